alu_8bit: RTL and testbench

//   Registered 8-bit integer ALU: 8 ops (arith, logic, shift) selected by a 3-bit code.

---
 rtl/alu_8bit.sv | 153 +++++++++++++++
 tb/tb_alu_8bit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// ---------------------------------------------------------------------------
// alu_8bit -- registered integer ALU used as the datapath execute stage.
//
// Eight operations (add, subtract, four logic ops, two shifts) are selected
// by a 3-bit opcode. The unit samples its operands on an enabled clock edge.
// It registers the result and the status flags, so results appear one cycle
// later. Downstream logic reads alu_out and the flags while out_valid is 1.
//
// Optional feature: define ALU_SATURATE_EN to make ADD clamp to all-ones when
// it carries out, and SUB clamp to zero when it borrows. In that build carry
// and overflow still report the raw arithmetic event. With the macro
// undefined, ADD and SUB wrap modulo 2^WIDTH.
//
// Parameters
//   WIDTH      operand/result width (>= 4); the shift amount is
//              B[$clog2(WIDTH)-1:0]
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   A          operand A
//   B          operand B / shift amount
//   operation  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//              101 NOT, 110 SHL, 111 SHR
//   en         1 = execute on this edge; 0 = hold result and flags
//   alu_out    registered result
//   carry      carry out (ADD), borrow (SUB), or last bit shifted out
//   zero       alu_out == 0
//   negative   alu_out[WIDTH-1]
//   overflow   signed overflow (ADD/SUB only)
//   out_valid  1 for the cycle after an enabled edge
// ---------------------------------------------------------------------------
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       operation,
  input  logic             en,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             out_valid
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_t;

  op_t             op;
  logic [SW-1:0]   shamt;
  logic [WIDTH:0]  sum_ext;
  logic [WIDTH:0]  diff_ext;
  logic [WIDTH:0]  shl_ext;
  logic [WIDTH:0]  shr_ext;
  logic [WIDTH-1:0] res_d;
  logic            carry_d;
  logic            overflow_d;

  assign op    = op_t'(operation);
  assign shamt = B[SW-1:0];

  // Every operation is computed one bit wider than WIDTH, so the extra bit
  // captures the carry, the borrow, or the bit shifted out.
  //   SHL: a zero is prepended above A. After a shift by n, bit WIDTH holds
  //        A[WIDTH-n], which is the last bit to leave the MSB.
  //   SHR: a zero is appended below A. After a shift by n, bit 0 holds
  //        A[n-1], which is the last bit to leave the LSB.
  // A shift of 0 leaves the guard bit at 0, so carry reads 0 in that case.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign shl_ext  = {1'b0, A} << shamt;
  assign shr_ext  = {A, 1'b0} >> shamt;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    res_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (op)
      OP_ADD: begin
        res_d      = sum_ext[WIDTH-1:0];
        carry_d    = sum_ext[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SATURATE_EN
        if (sum_ext[WIDTH]) res_d = '1;
`endif
      end
      OP_SUB: begin
        res_d      = diff_ext[WIDTH-1:0];
        carry_d    = diff_ext[WIDTH];          // borrow: 1 iff A < B unsigned
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) &&
                     (diff_ext[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SATURATE_EN
        if (diff_ext[WIDTH]) res_d = '0;
`endif
      end
      OP_AND: res_d = A & B;
      OP_OR:  res_d = A | B;
      OP_XOR: res_d = A ^ B;
      OP_NOT: res_d = ~A;
      OP_SHL: begin
        res_d   = shl_ext[WIDTH-1:0];
        carry_d = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_d   = shr_ext[WIDTH:1];
        carry_d = shr_ext[0];
      end
      default: ;
    endcase
  end

  // NOTE: all state is reset, including zero=1, so the flags agree with the
  // cleared result from the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before this edge.
      out_valid <= en;
      if (en) begin
        alu_out  <= res_d;
        carry    <= carry_d;
        zero     <= (res_d == '0);
        negative <= res_d[WIDTH-1];
        overflow <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// ---------------------------------------------------------------------------
// tb_alu_8bit -- directed self-checking bench for alu_8bit.
// Expected values are computed by hand. Compile with +define+ALU_SATURATE_EN
// to check the saturating build.
// ---------------------------------------------------------------------------
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] operation = '0;
  logic       en = 1'b0;
  logic [7:0] alu_out;
  logic       carry, zero, negative, overflow, out_valid;

  int checks = 0;
  int errors = 0;

  alu_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .operation (operation),
    .en        (en),
    .alu_out   (alu_out),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare the result, the four flags and out_valid against expectations.
  task automatic expect_all(input string tag, input logic [7:0] r,
                            input logic c, input logic z, input logic n,
                            input logic v, input logic ov);
    check({tag, ".out"},   {8'h00, alu_out}, {8'h00, r});
    check({tag, ".carry"}, {15'h0, carry},     {15'h0, c});
    check({tag, ".zero"},  {15'h0, zero},      {15'h0, z});
    check({tag, ".neg"},   {15'h0, negative},  {15'h0, n});
    check({tag, ".ovf"},   {15'h0, overflow},  {15'h0, v});
    check({tag, ".valid"}, {15'h0, out_valid}, {15'h0, ov});
  endtask

  // Drive the inputs at the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic e);
    @(negedge clk);
    A = a; B = b; operation = op; en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset, asserted and checked before the first clock edge.
    #2 rst = 1'b1;
    #1;
    expect_all("reset", 8'h00, 0, 1, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

`ifdef ALU_SATURATE_EN
    step(8'h11, 8'hFF, 3'b000, 1); expect_all("add_sat", 8'hFF, 1, 0, 1, 0, 1);
    // en=0 holds the result and flags even though the inputs change.
    step(8'h00, 8'h00, 3'b101, 0); expect_all("hold",    8'hFF, 1, 0, 1, 0, 0);
`else
    step(8'h11, 8'hFF, 3'b000, 1); expect_all("add_c",   8'h10, 1, 0, 0, 0, 1);
    step(8'h00, 8'h00, 3'b101, 0); expect_all("hold",    8'h10, 1, 0, 0, 0, 0);
`endif
    // Both operands are negative, so the signs are equal and there is no
    // signed overflow.
    step(8'hA9, 8'h90, 3'b001, 1); expect_all("sub",     8'h19, 0, 0, 0, 0, 1);
`ifdef ALU_SATURATE_EN
    step(8'h10, 8'h20, 3'b001, 1); expect_all("sub_bor", 8'h00, 1, 1, 0, 0, 1);
`else
    step(8'h10, 8'h20, 3'b001, 1); expect_all("sub_bor", 8'hF0, 1, 0, 1, 0, 1);
`endif
    step(8'h80, 8'h01, 3'b001, 1); expect_all("sub_ovf", 8'h7F, 0, 0, 0, 1, 1);
    step(8'h7F, 8'h01, 3'b000, 1); expect_all("add_ovf", 8'h80, 0, 0, 1, 1, 1);
    // The shift follows an op that set overflow; a shift must clear it.
    step(8'h81, 8'h01, 3'b110, 1); expect_all("shl1",    8'h02, 1, 0, 0, 0, 1);
`ifdef ALU_SATURATE_EN
    step(8'h80, 8'h80, 3'b000, 1); expect_all("add_cv",  8'hFF, 1, 0, 1, 1, 1);
`else
    step(8'h80, 8'h80, 3'b000, 1); expect_all("add_cv",  8'h00, 1, 1, 0, 1, 1);
`endif
    // The logic op follows an op that set both carry and overflow.
    step(8'h11, 8'hFF, 3'b011, 1); expect_all("or",      8'hFF, 0, 0, 1, 0, 1);
    step(8'h11, 8'hFF, 3'b010, 1); expect_all("and",     8'h11, 0, 0, 0, 0, 1);
    step(8'h11, 8'hFF, 3'b100, 1); expect_all("xor",     8'hEE, 0, 0, 1, 0, 1);
    step(8'h11, 8'hFF, 3'b101, 1); expect_all("not",     8'hEE, 0, 0, 1, 0, 1);
    step(8'h00, 8'h00, 3'b010, 1); expect_all("and_z",   8'h00, 0, 1, 0, 0, 1);
    // B=0B: the upper B bits are ignored, so the shift amount is 3.
    step(8'h21, 8'h0B, 3'b110, 1); expect_all("shl_hi",  8'h08, 1, 0, 0, 0, 1);
    step(8'hFF, 8'h07, 3'b110, 1); expect_all("shl7",    8'h80, 1, 0, 1, 0, 1);
    step(8'h81, 8'h00, 3'b110, 1); expect_all("shl0",    8'h81, 0, 0, 1, 0, 1);
    step(8'h81, 8'h03, 3'b111, 1); expect_all("shr3",    8'h10, 0, 0, 0, 0, 1);
    step(8'h81, 8'h01, 3'b111, 1); expect_all("shr1",    8'h40, 1, 0, 0, 0, 1);
    step(8'h81, 8'h07, 3'b111, 1); expect_all("shr7",    8'h01, 0, 0, 0, 0, 1);
    step(8'h81, 8'h00, 3'b111, 1); expect_all("shr0",    8'h81, 0, 0, 1, 0, 1);

    // A mid-stream reset discards the in-flight result.
    @(negedge clk);
    A = 8'h05; B = 8'h03; operation = 3'b000; en = 1'b1;
    #1 rst = 1'b1;
    #1;
    expect_all("rst_mid", 8'h00, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    expect_all("rst_hold", 8'h00, 0, 1, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    step(8'h01, 8'h02, 3'b000, 1); expect_all("post_rst", 8'h03, 0, 0, 0, 0, 1);
    step(8'h01, 8'h02, 3'b000, 0); expect_all("idle",     8'h03, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
